// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - shared state, opcode, funct and ALU-control encodings
package mc_controller_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b101
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// rtl/mc_controller_alu_decoder.sv - opcode/funct to ALU control and legality
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_cntrl,
    output logic       legal
);

    always_comb begin
        alu_cntrl = ALU_AND;
        legal     = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_cntrl = ALU_ADD;
                    FN_SUB:  alu_cntrl = ALU_SUB;
                    FN_AND:  alu_cntrl = ALU_AND;
                    FN_OR:   alu_cntrl = ALU_OR;
                    FN_SLT:  alu_cntrl = ALU_SLT;
                    FN_JR:   alu_cntrl = ALU_AND;
                    default: legal     = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: alu_cntrl = ALU_ADD;
            OP_SLTI:               alu_cntrl = ALU_SLT;
            OP_BEQ:                alu_cntrl = ALU_SUB;
            OP_J, OP_JAL:          alu_cntrl = ALU_AND;
            default:               legal     = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM with ready stalls and retire counter
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        ZERO,
    input  logic        i_ready,
    input  logic        d_ready,
    output logic        reg_dst,
    output logic        jal_reg,
    output logic        pc_to_reg,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        jump_sel,
    output logic        pc_jump,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  alu_cntrl,
    output logic        ir_write,
    output logic        pc_en,
    output logic        illegal,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d, fn_q, fn_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;

    logic [2:0]  dec_alu;
    logic        dec_legal;

    alu_decoder u_alu_decoder (
        .opcode    (op_q),
        .funct     (fn_q),
        .alu_cntrl (dec_alu),
        .legal     (dec_legal)
    );

    logic is_r, is_jr, is_lw, is_sw, is_beq, is_j, is_jal;
    assign is_r   = (op_q == OP_RTYPE);
    assign is_jr  = is_r && (fn_q == FN_JR);
    assign is_lw  = (op_q == OP_LW);
    assign is_sw  = (op_q == OP_SW);
    assign is_beq = (op_q == OP_BEQ);
    assign is_j   = (op_q == OP_J);
    assign is_jal = (op_q == OP_JAL);

    logic       c_reg_dst, c_jal_reg, c_pc_to_reg, c_alu_src, c_mem_to_reg;
    logic       c_jump_sel, c_pc_jump, c_pc_src, c_reg_write, c_mem_read;
    logic       c_mem_write, c_ir_write, c_pc_en;
    logic [2:0] c_alu_cntrl;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        fn_d         = fn_q;
        illegal_d    = illegal_q;
        c_reg_dst    = 1'b0;
        c_jal_reg    = 1'b0;
        c_pc_to_reg  = 1'b0;
        c_alu_src    = 1'b0;
        c_mem_to_reg = 1'b0;
        c_jump_sel   = 1'b0;
        c_pc_jump    = 1'b0;
        c_pc_src     = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_ir_write   = 1'b0;
        c_pc_en      = 1'b0;
        c_alu_cntrl  = ALU_AND;
        case (state_q)
            S_FETCH: begin
                c_ir_write = 1'b1;
                if (i_ready) begin
                    op_d    = opcode;
                    fn_d    = funct;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                c_alu_cntrl = dec_alu;
                if (is_beq) begin
                    c_pc_src = ZERO;
                    c_pc_en  = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_j || is_jal) begin
                    c_pc_jump   = 1'b1;
                    c_jump_sel  = 1'b1;
                    c_pc_en     = 1'b1;
                    c_jal_reg   = is_jal;
                    c_pc_to_reg = is_jal;
                    c_reg_write = is_jal;
                    state_d     = S_FETCH;
                end else if (is_jr) begin
                    c_pc_jump = 1'b1;
                    c_pc_en   = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_lw || is_sw) begin
                    c_alu_src = 1'b1;
                    state_d   = S_MEM;
                end else begin
                    c_alu_src = !is_r;
                    state_d   = S_WB;
                end
            end
            S_MEM: begin
                c_alu_src   = 1'b1;
                c_alu_cntrl = dec_alu;
                c_mem_read  = is_lw;
                c_mem_write = is_sw;
                if (d_ready) begin
                    c_pc_en = is_sw;
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                c_reg_write  = 1'b1;
                c_pc_en      = 1'b1;
                c_alu_src    = !is_r;
                c_alu_cntrl  = dec_alu;
                c_reg_dst    = is_r;
                c_mem_to_reg = is_lw;
                state_d      = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        retired_d = retired_q + {31'b0, c_pc_en};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'b0;
            fn_q      <= 6'b0;
            illegal_q <= 1'b0;
            retired_q <= 32'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Gating with rst kills strobes the instant reset asserts, so no partial commit.
    assign reg_dst    = rst & c_reg_dst;
    assign jal_reg    = rst & c_jal_reg;
    assign pc_to_reg  = rst & c_pc_to_reg;
    assign alu_src    = rst & c_alu_src;
    assign mem_to_reg = rst & c_mem_to_reg;
    assign jump_sel   = rst & c_jump_sel;
    assign pc_jump    = rst & c_pc_jump;
    assign pc_src     = rst & c_pc_src;
    assign reg_write  = rst & c_reg_write;
    assign mem_read   = rst & c_mem_read;
    assign mem_write  = rst & c_mem_write;
    assign ir_write   = rst & c_ir_write;
    assign pc_en      = rst & c_pc_en;
    assign alu_cntrl  = rst ? c_alu_cntrl : 3'b000;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule
